wrr_scheduler: RTL and testbench

- Parametrised round-robin scheduler with per-input valid/ready handshakes and a registered, back-pressurable output.
- Work-conserving: it skips inputs with no valid data instead of forwarding idle slots.
- MODE selects plain round-robin or weighted round-robin, where each input gets a burst of up to its weight in transfers.
- Sits between N_INPUTS producer queues and one downstream consumer.

---
 rtl/sched_pkg.sv | 14 +
 rtl/wrr_scheduler_if.sv | 28 ++
 rtl/rr_priority_pick.sv | 29 ++
 rtl/wrr_scheduler.sv | 81 ++++++++
 tb/tb_wrr_scheduler.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/sched_pkg.sv
// Shared constants and width helpers for the weighted round-robin scheduler.
package sched_pkg;
  localparam int MODE_RR  = 0;
  localparam int MODE_WRR = 1;

  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // A burst counter never needs more range than the weight field feeding it.
  function automatic int credit_width(input int weight_width);
    return weight_width;
  endfunction
endpackage

// File: rtl/wrr_scheduler_if.sv
// Producer-side and consumer-side handshake bundle of the scheduler.
interface wrr_scheduler_if
  import sched_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int N_INPUTS     = 4,
  parameter int WEIGHT_WIDTH = 4
);
  localparam int SEL_W = sel_width(N_INPUTS);

  logic [DATA_WIDTH*N_INPUTS-1:0]   r_in;
  logic [N_INPUTS-1:0]              in_valid;
  logic [N_INPUTS-1:0]              in_ready;
  logic [WEIGHT_WIDTH*N_INPUTS-1:0] weights;
  logic [DATA_WIDTH-1:0]            data_out;
  logic                             out_valid;
  logic                             out_ready;
  logic [SEL_W-1:0]                 out_sel;

  modport master (
    output r_in, in_valid, weights, out_ready,
    input  in_ready, data_out, out_valid, out_sel
  );
  modport slave (
    input  r_in, in_valid, weights, out_ready,
    output in_ready, data_out, out_valid, out_sel
  );
endinterface

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: first set request at or after start, wrapping at N.
module rr_priority_pick
  import sched_pkg::*;
#(
  parameter int N = 4,
  localparam int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] gnt,
  output logic             gnt_vld
);
  logic [SEL_W:0] idx;

  // One extra bit holds start+k before the wrap, so non-power-of-2 N wraps exactly.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, start} + (SEL_W+1)'(k);
      if (idx >= (SEL_W+1)'(N)) idx = idx - (SEL_W+1)'(N);
      if (!gnt_vld && req[idx[SEL_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = idx[SEL_W-1:0];
      end
    end
  end
endmodule

// File: rtl/wrr_scheduler.sv
// Work-conserving (weighted) round-robin scheduler with a registered, back-pressurable output.
module wrr_scheduler
  import sched_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int N_INPUTS     = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int MODE         = MODE_RR
) (
  input logic          clk,
  input logic          rst,
  wrr_scheduler_if.slave bus
);
  localparam int SEL_W  = sel_width(N_INPUTS);
  localparam int CRED_W = credit_width(WEIGHT_WIDTH);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_INPUTS-1);

  logic [N_INPUTS-1:0][DATA_WIDTH-1:0]   lane_data;
  logic [N_INPUTS-1:0][WEIGHT_WIDTH-1:0] lane_wt;
  logic [SEL_W-1:0]      ptr, gnt, nxt, sel_q;
  logic [CRED_W-1:0]     credit, eff_w;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  vld_q, gnt_vld, load, xfer, burst_start;

  assign lane_data = bus.r_in;
  assign lane_wt   = bus.weights;

  rr_priority_pick #(.N(N_INPUTS)) u_pick (
    .req     (bus.in_valid),
    .start   (ptr),
    .gnt     (gnt),
    .gnt_vld (gnt_vld)
  );

  assign load        = !vld_q || bus.out_ready;
  assign xfer        = gnt_vld && load && !rst;
  assign nxt         = (gnt == LAST) ? '0 : gnt + 1'b1;
  assign eff_w       = (lane_wt[gnt] == '0) ? CRED_W'(1) : lane_wt[gnt];
  // Any grant away from ptr abandons the old burst and starts a fresh one.
  assign burst_start = (credit == '0) || (gnt != ptr);

  always_comb begin
    bus.in_ready = '0;
    if (xfer) bus.in_ready[gnt] = 1'b1;
  end

  assign bus.data_out  = data_q;
  assign bus.out_valid = vld_q;
  assign bus.out_sel   = sel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      credit <= '0;
      vld_q  <= 1'b0;
      data_q <= '0;
      sel_q  <= '0;
    end else begin
      if (xfer) begin
        data_q <= lane_data[gnt];
        sel_q  <= gnt;
        vld_q  <= 1'b1;
      end else if (bus.out_ready) begin
        vld_q  <= 1'b0;
      end
      if (xfer) begin
        if (MODE == MODE_WRR) begin
          if (burst_start) begin
            credit <= eff_w - 1'b1;
            ptr    <= (eff_w == CRED_W'(1)) ? nxt : gnt;
          end else begin
            credit <= credit - 1'b1;
            ptr    <= (credit == CRED_W'(1)) ? nxt : ptr;
          end
        end else begin
          ptr <= nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_wrr_scheduler.sv
// Directed bench: three scheduler configurations checked against expected-output queues.
module tb_wrr_scheduler;
  typedef struct { int sel; logic [15:0] data; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int   nchk  = 0;
  int   nfail = 0;
  bit   sb_en = 1'b0;
  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;

  logic [15:0] da [4] = '{16'hAAAA, 16'h1111, 16'h2222, 16'h3333};
  logic [15:0] db [4] = '{16'hB000, 16'hB001, 16'hB002, 16'hB003};
  logic [15:0] dc [3] = '{16'hC000, 16'hC001, 16'hC002};

  wrr_scheduler_if #(.DATA_WIDTH(16), .N_INPUTS(4), .WEIGHT_WIDTH(4)) ia ();
  wrr_scheduler_if #(.DATA_WIDTH(16), .N_INPUTS(4), .WEIGHT_WIDTH(4)) ib ();
  wrr_scheduler_if #(.DATA_WIDTH(16), .N_INPUTS(3), .WEIGHT_WIDTH(4)) ic ();

  wrr_scheduler #(.DATA_WIDTH(16), .N_INPUTS(4), .WEIGHT_WIDTH(4), .MODE(0)) ua (.clk(clk), .rst(rst), .bus(ia));
  wrr_scheduler #(.DATA_WIDTH(16), .N_INPUTS(4), .WEIGHT_WIDTH(4), .MODE(1)) ub (.clk(clk), .rst(rst), .bus(ib));
  wrr_scheduler #(.DATA_WIDTH(16), .N_INPUTS(3), .WEIGHT_WIDTH(4), .MODE(0)) uc (.clk(clk), .rst(rst), .bus(ic));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pa(input int s); qa.push_back('{s, da[s]}); endtask
  task automatic pb(input int s); qb.push_back('{s, db[s]}); endtask
  task automatic pc(input int s); qc.push_back('{s, dc[s]}); endtask

  // A word is consumed on the next edge when out_valid && out_ready at the negedge.
  always @(negedge clk) if (sb_en && !rst && ia.out_valid && ia.out_ready) begin
    if (qa.size() == 0) chk("a_unexpected_word", 32'(ia.out_sel), 32'hFFFF);
    else begin
      ea = qa.pop_front();
      chk("a_sel", 32'(ia.out_sel), 32'(ea.sel));
      chk("a_data", 32'(ia.data_out), 32'(ea.data));
    end
  end

  always @(negedge clk) if (sb_en && !rst && ib.out_valid && ib.out_ready) begin
    if (qb.size() == 0) chk("b_unexpected_word", 32'(ib.out_sel), 32'hFFFF);
    else begin
      eb = qb.pop_front();
      chk("b_sel", 32'(ib.out_sel), 32'(eb.sel));
      chk("b_data", 32'(ib.data_out), 32'(eb.data));
    end
  end

  always @(negedge clk) if (sb_en && !rst && ic.out_valid && ic.out_ready) begin
    if (qc.size() == 0) chk("c_unexpected_word", 32'(ic.out_sel), 32'hFFFF);
    else begin
      ec = qc.pop_front();
      chk("c_sel", 32'(ic.out_sel), 32'(ec.sel));
      chk("c_data", 32'(ic.data_out), 32'(ec.data));
    end
  end

  initial begin
    ia.r_in = {da[3], da[2], da[1], da[0]}; ia.weights = '0; ia.out_ready = 1'b1;
    ib.r_in = {db[3], db[2], db[1], db[0]}; ib.weights = '0; ib.out_ready = 1'b1;
    ic.r_in = {dc[2], dc[1], dc[0]};        ic.weights = '0; ic.out_ready = 1'b1;
    ia.in_valid = 4'hF; ib.in_valid = '0; ic.in_valid = '0;

    // Reset state, with requests pending
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ia.out_valid), 0);
    chk("rst_data_out", 32'(ia.data_out), 0);
    chk("rst_out_sel", 32'(ia.out_sel), 0);
    chk("rst_in_ready", 32'(ia.in_ready), 0);
    rst = 1'b0;
    #1;
    chk("first_grant_in_ready", 32'(ia.in_ready), 32'h1);
    step();
    chk("t1_sel0", 32'(ia.out_sel), 0);
    chk("t1_data0", 32'(ia.data_out), 32'hAAAA);
    step();
    chk("t1_sel1", 32'(ia.out_sel), 1);
    chk("t1_valid_mid", 32'(ia.out_valid), 1);

    // Asynchronous reset mid-stream
    #2 rst = 1'b1;
    #1;
    chk("t1_async_out_valid", 32'(ia.out_valid), 0);
    chk("t1_async_data_out", 32'(ia.data_out), 0);
    chk("t1_async_out_sel", 32'(ia.out_sel), 0);
    chk("t1_async_in_ready", 32'(ia.in_ready), 0);
    rst = 1'b0;
    #1;
    chk("t1_post_rst_grant", 32'(ia.in_ready), 32'h1);
    step();
    chk("t1_post_rst_sel", 32'(ia.out_sel), 0);
    chk("t1_post_rst_data", 32'(ia.data_out), 32'hAAAA);
    ia.in_valid = '0;
    step();
    chk("t1_drain", 32'(ia.out_valid), 0);
    sb_en = 1'b1;

    // Skip empty inputs
    ia.in_valid = 4'b1010;
    pa(1); pa(3); pa(1); pa(3);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_no_ready_0_2", 32'(ia.in_ready & 4'b0101), 0);
      step();
      chk("t2_valid_cont", 32'(ia.out_valid), 1);
    end
    ia.in_valid = '0;
    step();
    chk("t2_idle", 32'(ia.out_valid), 0);
    chk("t2_queue_empty", 32'(qa.size()), 0);

    // Back-pressure
    ia.in_valid = 4'hF;
    pa(0); pa(1);
    step();
    ia.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_hold_in_ready", 32'(ia.in_ready), 0);
      step();
      chk("t3_hold_data", 32'(ia.data_out), 32'hAAAA);
      chk("t3_hold_sel", 32'(ia.out_sel), 0);
      chk("t3_hold_valid", 32'(ia.out_valid), 1);
    end
    ia.out_ready = 1'b1;
    #1;
    chk("t3_release_grant", 32'(ia.in_ready), 32'h2);
    step();
    ia.in_valid = '0;
    step();
    chk("t3_idle", 32'(ia.out_valid), 0);
    chk("t3_queue_empty", 32'(qa.size()), 0);

    // Weighted bursts, weight 0 treated as 1
    ib.weights = 16'h1203;
    ib.in_valid = 4'hF;
    pb(0); pb(0); pb(0); pb(1); pb(2); pb(2); pb(3);
    repeat (7) step();
    ib.in_valid = '0;
    step();
    chk("t4_idle", 32'(ib.out_valid), 0);
    chk("t4_queue_empty", 32'(qb.size()), 0);

    // Burst abort discards leftover credit
    ib.weights = 16'h1114;
    ib.in_valid = 4'hF;
    pb(0); pb(0);
    repeat (2) step();
    ib.in_valid = 4'b1110;
    pb(1); pb(2); pb(3);
    repeat (3) step();
    ib.in_valid = 4'hF;
    pb(0); pb(0); pb(0); pb(0); pb(1);
    repeat (5) step();
    ib.in_valid = '0;
    step();
    chk("t5_idle", 32'(ib.out_valid), 0);
    chk("t5_queue_empty", 32'(qb.size()), 0);

    // Non-power-of-2 wrap
    ic.in_valid = 3'b111;
    pc(0); pc(1); pc(2); pc(0); pc(1); pc(2);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t6_sel_in_range", 32'(ic.out_sel < 2'd3), 1);
    end
    ic.in_valid = '0;
    step();
    chk("t6_idle", 32'(ic.out_valid), 0);
    chk("t6_queue_empty", 32'(qc.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
